// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash READ responder; miso follows a detected sck fall by 3 clk, master paces all transfers.
// SPI_FLASH_JEDEC_ID_EN adds the 0x9F JEDEC ID reply; the ROM image is MEM_INIT with byte i at bits [8i+7:8i].
module spi_flash_responder #(
  parameter int                     MEM_DEPTH = 256,
  parameter logic [7:0]             CMD_READ  = 8'h03,
  parameter logic [8*MEM_DEPTH-1:0] MEM_INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        busy,
  output logic        bad_cmd,
  output logic [15:0] tx_count
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int RW = (AW > 8) ? AW : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
`ifdef SPI_FLASH_JEDEC_ID_EN
    , S_ID
`endif
  } state_t;

  logic          cs_s1, cs_s2, cs_d;
  logic          sck_s1, sck_s2, sck_d;
  logic          mosi_s1, mosi_s2;
  logic [1:0]    fill;
  logic          armed;
  logic          cs_rise, cs_fall, sck_rise, sck_fall;

  state_t        state, state_nxt;
  logic [4:0]    bit_cnt, bit_cnt_nxt;
  logic [RW-1:0] rx_shift, rx_shift_nxt, rx_next;
  logic [AW-1:0] addr, addr_nxt, addr_inc, rd_addr;
  logic [7:0]    tx_shift, tx_shift_nxt, rom_rdat;
  logic          skip_fall, skip_fall_nxt;
  logic          miso_nxt, bad_cmd_nxt;
  logic [15:0]   tx_count_nxt;
`ifdef SPI_FLASH_JEDEC_ID_EN
  logic [1:0]    id_idx, id_idx_nxt;
`endif

  // A cs fall is only trusted once cs has been seen high through a refilled synchronizer,
  // so a transaction interrupted by rst stays ignored until cs cycles high then low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && cs_s2) armed <= 1'b1;
    end
  end

  assign cs_rise  = cs_s2 & ~cs_d;
  assign cs_fall  = armed & ~cs_s2 & cs_d;
  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;

  assign rx_next  = RW'({rx_shift, mosi_s2});
  assign addr_inc = addr + AW'(1);
  assign rd_addr  = (state == S_ADDR) ? rx_next[AW-1:0] : addr_inc;
  assign rom_rdat = MEM_INIT[{rd_addr, 3'b000} +: 8];

`ifdef SPI_FLASH_JEDEC_ID_EN
  assign busy = (state == S_ADDR) || (state == S_DATA) || (state == S_ID);
`else
  assign busy = (state == S_ADDR) || (state == S_DATA);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      addr      <= '0;
      tx_shift  <= '0;
      skip_fall <= 1'b0;
      miso      <= 1'b0;
      bad_cmd   <= 1'b0;
      tx_count  <= '0;
`ifdef SPI_FLASH_JEDEC_ID_EN
      id_idx    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_shift  <= rx_shift_nxt;
      addr      <= addr_nxt;
      tx_shift  <= tx_shift_nxt;
      skip_fall <= skip_fall_nxt;
      miso      <= miso_nxt;
      bad_cmd   <= bad_cmd_nxt;
      tx_count  <= tx_count_nxt;
`ifdef SPI_FLASH_JEDEC_ID_EN
      id_idx    <= id_idx_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_shift_nxt  = rx_shift;
    addr_nxt      = addr;
    tx_shift_nxt  = tx_shift;
    skip_fall_nxt = skip_fall;
    miso_nxt      = miso;
    bad_cmd_nxt   = 1'b0;
    tx_count_nxt  = tx_count;
`ifdef SPI_FLASH_JEDEC_ID_EN
    id_idx_nxt    = id_idx;
`endif
    if (cs_rise) begin
      state_nxt = S_IDLE;
      miso_nxt  = 1'b0;
    end else if (cs_fall) begin
      state_nxt     = S_CMD;
      bit_cnt_nxt   = '0;
      rx_shift_nxt  = '0;
      skip_fall_nxt = 1'b0;
      miso_nxt      = 1'b0;
      tx_count_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: ;
        S_CMD: if (sck_rise) begin
          rx_shift_nxt = rx_next;
          if (bit_cnt == 5'd7) begin
            bit_cnt_nxt = '0;
            if (rx_next[7:0] == CMD_READ) begin
              state_nxt = S_ADDR;
            end
`ifdef SPI_FLASH_JEDEC_ID_EN
            else if (rx_next[7:0] == 8'h9F) begin
              state_nxt     = S_ID;
              tx_shift_nxt  = 8'hEF;
              miso_nxt      = 1'b1;
              skip_fall_nxt = 1'b1;
              id_idx_nxt    = '0;
            end
`endif
            else begin
              bad_cmd_nxt = 1'b1;
              state_nxt   = S_IGNORE;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        S_ADDR: if (sck_rise) begin
          rx_shift_nxt = rx_next;
          if (bit_cnt == 5'd23) begin
            // The fall of this same sck cycle must not advance the freshly loaded byte.
            state_nxt     = S_DATA;
            bit_cnt_nxt   = '0;
            addr_nxt      = rx_next[AW-1:0];
            tx_shift_nxt  = rom_rdat;
            miso_nxt      = rom_rdat[7];
            skip_fall_nxt = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        S_DATA: if (sck_fall) begin
          if (skip_fall) begin
            skip_fall_nxt = 1'b0;
          end else if (bit_cnt == 5'd7) begin
            bit_cnt_nxt  = '0;
            addr_nxt     = addr_inc;
            tx_shift_nxt = rom_rdat;
            miso_nxt     = rom_rdat[7];
            tx_count_nxt = tx_count + 16'd1;
          end else begin
            bit_cnt_nxt  = bit_cnt + 5'd1;
            tx_shift_nxt = tx_shift << 1;
            miso_nxt     = tx_shift[6];
          end
        end
`ifdef SPI_FLASH_JEDEC_ID_EN
        S_ID: if (sck_fall) begin
          if (skip_fall) begin
            skip_fall_nxt = 1'b0;
          end else if (bit_cnt == 5'd7) begin
            bit_cnt_nxt  = '0;
            tx_shift_nxt = (id_idx == 2'd0) ? 8'h40 : 8'h16;
            miso_nxt     = (id_idx == 2'd0) ? 1'b0 : 1'b0;
            id_idx_nxt   = (id_idx == 2'd2) ? 2'd2 : id_idx + 2'd1;
            tx_count_nxt = tx_count + 16'd1;
          end else begin
            bit_cnt_nxt  = bit_cnt + 5'd1;
            tx_shift_nxt = tx_shift << 1;
            miso_nxt     = tx_shift[6];
          end
        end
`endif
        S_IGNORE: miso_nxt = 1'b0;
        default: begin
          state_nxt = S_IDLE;
          miso_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: the bench acts as SPI master, expected bytes queue up as commands are issued.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  function automatic logic [7:0] img_byte(input int i);
    case (i)
      0:       return 8'h1F;
      1:       return 8'h85;
      2:       return 8'h01;
      255:     return 8'hA7;
      default: return 8'(i) ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [2047:0] build_img();
    logic [2047:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r[8*i +: 8] = img_byte(i);
    return r;
  endfunction

  localparam logic [2047:0] IMG = build_img();

  logic        clk = 1'b0;
  logic        rst, cs, sck, mosi;
  logic        miso, busy, bad_cmd;
  logic [15:0] tx_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          bad_hi   = 0;
  int          exp_busy = -1;
  logic [7:0]  exp_q[$];

  spi_flash_responder #(
    .MEM_DEPTH(256),
    .CMD_READ (8'h03),
    .MEM_INIT (IMG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .busy    (busy),
    .bad_cmd (bad_cmd),
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bad_cmd === 1'b1) bad_hi = bad_hi + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 0 master: mosi set during low phase, miso sampled as sck rises.
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7-i];
      tick(HALF);
      sck = 1'b1;
      rx = {rx[6:0], miso};
      if (exp_busy >= 0) check("busy_during_bit", 32'(busy), 32'(exp_busy));
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    spi_bits(b, 8, rx);
  endtask

  task automatic read_bytes(input int n, input string tag);
    logic [7:0] rx;
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, rx);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s observed=%0h expected=<empty queue>", tag, rx);
      end else begin
        check(tag, 32'(rx), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(4);
    cs = 1'b1;
    tick(HALF);
  endtask

  initial begin
    int         b0;
    logic [7:0] rx;
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tick(4);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bad_cmd", 32'(bad_cmd), 32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    rst = 1'b0;
    tick(4);

    // Basic READ from address 0
    cs_low();
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    exp_q.push_back(img_byte(0)); exp_q.push_back(img_byte(1)); exp_q.push_back(img_byte(2));
    exp_busy = 1;
    read_bytes(3, "read0_data");
    exp_busy = -1;
    tick(4);
    check("read0_tx_count", 32'(tx_count), 32'd3);
    check("read0_busy_end", 32'(busy), 32'd1);
    cs = 1'b1;
    tick(HALF);
    check("read0_idle_busy", 32'(busy), 32'd0);
    check("read0_idle_miso", 32'(miso), 32'd0);
    check("read0_count_held", 32'(tx_count), 32'd3);

    // Address wrap FF -> 00
    cs_low();
    check("wrap_count_clear", 32'(tx_count), 32'd0);
    send(8'h03); send(8'h00); send(8'h00); send(8'hFF);
    exp_q.push_back(img_byte(255)); exp_q.push_back(img_byte(0));
    read_bytes(2, "wrap_data");
    tick(4);
    check("wrap_tx_count", 32'(tx_count), 32'd2);
    cs_high();

    // Unknown opcode
    b0 = bad_hi;
    cs_low();
    send(8'hA5);
    tick(HALF);
    check("bad_pulse_cnt", 32'(bad_hi - b0), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_busy = 0;
    read_bytes(2, "bad_miso");
    exp_busy = -1;
    check("bad_tx_count", 32'(tx_count), 32'd0);
    cs_high();

    // Abort mid byte 2, then a fresh READ
    cs_low();
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    exp_q.push_back(img_byte(0));
    read_bytes(1, "abort_byte1");
    spi_bits(8'h00, 4, rx);
    cs = 1'b1;
    tick(HALF);
    check("abort_miso", 32'(miso), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_count", 32'(tx_count), 32'd1);
    cs_low();
    check("abort_count_clear", 32'(tx_count), 32'd0);
    send(8'h03); send(8'h00); send(8'h00); send(8'h01);
    exp_q.push_back(img_byte(1));
    read_bytes(1, "restart_data");
    cs_high();

    // rst during address bit 10; the rest of that transaction must be ignored
    b0 = bad_hi;
    cs_low();
    send(8'h03);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 2, rx);
    rst = 1'b1;
    tick(2);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bad_cmd", 32'(bad_cmd), 32'd0);
    check("midrst_tx_count", 32'(tx_count), 32'd0);
    rst = 1'b0;
    spi_bits(8'h00, 6, rx);
    spi_bits(8'h00, 8, rx);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_busy = 0;
    read_bytes(2, "midrst_ignored");
    exp_busy = -1;
    check("midrst_no_bad", 32'(bad_hi - b0), 32'd0);
    check("midrst_count", 32'(tx_count), 32'd0);
    cs_high();
    cs_low();
    send(8'h03); send(8'h00); send(8'h00); send(8'h02);
    exp_q.push_back(img_byte(2));
    read_bytes(1, "postrst_data");
    tick(4);
    check("postrst_tx_count", 32'(tx_count), 32'd1);
    cs_high();

    // JEDEC ID opcode
    b0 = bad_hi;
    cs_low();
    send(8'h9F);
`ifdef SPI_FLASH_JEDEC_ID_EN
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
    exp_q.push_back(8'h16); exp_q.push_back(8'h16);
    exp_busy = 1;
    read_bytes(4, "jedec_id");
    exp_busy = -1;
    tick(4);
    check("jedec_tx_count", 32'(tx_count), 32'd4);
    check("jedec_no_bad", 32'(bad_hi - b0), 32'd0);
`else
    tick(HALF);
    check("jedec_bad_pulse", 32'(bad_hi - b0), 32'd1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_busy = 0;
    read_bytes(4, "jedec_miso_zero");
    exp_busy = -1;
    check("jedec_tx_count", 32'(tx_count), 32'd0);
`endif
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
